ripple_count_ctrl: RTL and testbench

//  Sequencer for a SIZE-bit asynchronous (ripple) JK up/down counter. Accepts step commands
//  (direction + step count), generates the counter's clock pulses, and switches direction

---
 rtl/ripple_count_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_ripple_count_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_ctrl.sv
// ripple_count_ctrl
//   Sequencer for a SIZE-bit asynchronous (ripple) JK up/down counter.
//   It takes step commands (direction + step count) and generates the stage-0
//   clock pulses for the counter. When the direction changes, it holds J=K=0
//   while the stage-clock mux switches. After each pulse it waits a settle
//   window and compares the rippled count against a shadow count.
//
//   Command handshake: a command (cmd_dir, cmd_steps) or a clear (clr_req)
//   is taken on a rising clk edge where its request is high and cmd_ready is
//   high. cmd_ready is high only while the sequencer is idle. Requests seen
//   while cmd_ready is low are ignored, not queued, so the requester must hold
//   the request until cmd_ready is high. clr_req wins over cmd_valid when both
//   are taken on the same edge.
//
// Ports
//   clk        in   1     system clock, rising edge
//   rst        in   1     asynchronous active-high reset
//   cmd_valid  in   1     command request
//   cmd_ready  out  1     idle, a request can be taken
//   cmd_dir    in   1     1 = count up, 0 = count down
//   cmd_steps  in   SIZE  number of steps (0 allowed)
//   clr_req    in   1     clear request
//   cnt_q      in   SIZE  counter outputs
//   cnt_clk    out  1     counter stage-0 clock
//   cnt_rst    out  1     counter reset
//   cnt_mode   out  1     0 = up (qbar clocks next stage), 1 = down
//   cnt_jk     out  1     J and K of all stages (1 = toggle, 0 = hold)
//   value      out  SIZE  shadow count, updated after each verified step
//   busy       out  1     complement of cmd_ready
//   done       out  1     one-cycle pulse at command end
//   sat        out  1     with done: command stopped at a limit (no-wrap build)
//   err        out  1     sticky: sampled cnt_q differed from the shadow count

module ripple_count_ctrl #(
   parameter int SIZE       = 4,
   parameter int SETTLE_CYC = 2,
   parameter bit WRAP_EN    = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_dir,
   input  logic [SIZE-1:0] cmd_steps,
   input  logic            clr_req,
   input  logic [SIZE-1:0] cnt_q,
   output logic            cnt_clk,
   output logic            cnt_rst,
   output logic            cnt_mode,
   output logic            cnt_jk,
   output logic [SIZE-1:0] value,
   output logic            busy,
   output logic            done,
   output logic            sat,
   output logic            err
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CLR      = 3'd1,
      MODE_SW  = 3'd2,
      PULSE_HI = 3'd3,
      PULSE_LO = 3'd4,
      SETTLE   = 3'd5,
      CHECK    = 3'd6
   } state_t;

   localparam int              WW        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [WW-1:0]   WAIT_LOAD = WW'(SETTLE_CYC - 1);
   localparam logic [SIZE-1:0] MAX_VAL   = '1;

   state_t          state, state_d;
   logic [WW-1:0]   wait_cnt, wait_d;
   logic [SIZE-1:0] rem, rem_d;
   logic [SIZE-1:0] shadow, shadow_d;
   logic            dir_q, dir_d;
   logic            clr_phase, clr_phase_d;   // SETTLE belongs to a clear, not a step
   logic            sat_stop;

   logic            cnt_clk_d, cnt_rst_d, cnt_mode_d, cnt_jk_d;
   logic [SIZE-1:0] value_d;
   logic            done_d, sat_d, err_d, ready_d;

   // Limits only matter when wrapping is disabled.
   logic at_limit, cmd_limit;
   assign at_limit  = !WRAP_EN && (dir_q   ? (shadow == MAX_VAL) : (shadow == '0));
   assign cmd_limit = !WRAP_EN && (cmd_dir ? (shadow == MAX_VAL) : (shadow == '0));

   // State and datapath register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         rem       <= '0;
         shadow    <= '0;
         dir_q     <= 1'b0;
         clr_phase <= 1'b0;
         cnt_clk   <= 1'b0;
         cnt_rst   <= 1'b1;
         cnt_mode  <= 1'b0;
         cnt_jk    <= 1'b0;
         value     <= '0;
         done      <= 1'b0;
         sat       <= 1'b0;
         err       <= 1'b0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state     <= state_d;
         wait_cnt  <= wait_d;
         rem       <= rem_d;
         shadow    <= shadow_d;
         dir_q     <= dir_d;
         clr_phase <= clr_phase_d;
         cnt_clk   <= cnt_clk_d;
         cnt_rst   <= cnt_rst_d;
         cnt_mode  <= cnt_mode_d;
         cnt_jk    <= cnt_jk_d;
         value     <= value_d;
         done      <= done_d;
         sat       <= sat_d;
         err       <= err_d;
         cmd_ready <= ready_d;
         busy      <= !ready_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state;
      wait_d      = wait_cnt;
      rem_d       = rem;
      shadow_d    = shadow;
      dir_d       = dir_q;
      clr_phase_d = clr_phase;
      sat_stop    = 1'b0;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_d     = CLR;
               clr_phase_d = 1'b1;
            end else if (cmd_valid) begin
               dir_d = cmd_dir;
               rem_d = cmd_steps;
               if (cmd_steps == '0) begin
                  state_d = IDLE;
               end else if ((~cmd_dir) != cnt_mode) begin
                  state_d = MODE_SW;
                  wait_d  = WAIT_LOAD;
               end else if (cmd_limit) begin
                  sat_stop = 1'b1;
               end else begin
                  state_d = PULSE_HI;
               end
            end
         end
         CLR: begin
            state_d  = SETTLE;
            wait_d   = WAIT_LOAD;
            shadow_d = '0;
         end
         MODE_SW: begin
            if (wait_cnt == '0) begin
               if (at_limit) begin
                  sat_stop = 1'b1;
                  state_d  = IDLE;
               end else begin
                  state_d = PULSE_HI;
               end
            end else begin
               wait_d = wait_cnt - WW'(1);
            end
         end
         PULSE_HI: begin
            state_d  = PULSE_LO;
            shadow_d = dir_q ? (shadow + SIZE'(1)) : (shadow - SIZE'(1));
         end
         PULSE_LO: begin
            state_d = SETTLE;
            wait_d  = WAIT_LOAD;
         end
         SETTLE: begin
            if (wait_cnt == '0) begin
               state_d     = clr_phase ? IDLE : CHECK;
               clr_phase_d = 1'b0;
            end else begin
               wait_d = wait_cnt - WW'(1);
            end
         end
         CHECK: begin
            if (cnt_q == shadow) begin
               rem_d = rem - SIZE'(1);
               if (rem == SIZE'(1)) begin
                  state_d = IDLE;
               end else if (at_limit) begin
                  sat_stop = 1'b1;
                  state_d  = IDLE;
               end else begin
                  state_d = PULSE_HI;
               end
            end else begin
               // Resynchronise to what the counter actually holds and abort.
               shadow_d = cnt_q;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      cnt_clk_d  = (state_d == PULSE_HI);
      cnt_rst_d  = (state_d == CLR);
      // Mode and J/K change on the same edge: the stages see J=K=0 before
      // any edge from the mode mux can reach a clock input.
      cnt_mode_d = (state_d == MODE_SW) ? ~dir_d : cnt_mode;
      cnt_jk_d   = cnt_jk;
      if (state_d == MODE_SW) begin
         cnt_jk_d = 1'b0;
      end else if ((state == MODE_SW) || (state_d == PULSE_HI)) begin
         cnt_jk_d = 1'b1;
      end
      value_d = value;
      err_d   = err;
      if (state_d == CLR) begin
         value_d = '0;
         err_d   = 1'b0;
      end
      if (state == CHECK) begin
         if (cnt_q == shadow) begin
            value_d = shadow;
         end else begin
            value_d = cnt_q;
            err_d   = 1'b1;
         end
      end
      // A command ends from MODE_SW (limit), CHECK, or directly from IDLE
      // (zero steps or already at a limit). A clear never pulses done.
      done_d  = (state_d == IDLE) &&
                ((state == MODE_SW) || (state == CHECK) ||
                 ((state == IDLE) && cmd_valid && !clr_req));
      sat_d   = sat_stop;
      ready_d = (state_d == IDLE);
   end

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// tb_ripple_count_ctrl
//   Two sequencers share clk and rst: instance 0 wraps and instance 1
//   saturates. Each drives a behavioural JK ripple counter. A stuck-at-0 fault
//   can be forced on bit 1 of either counter. Command results are predicted
//   from the step rules with plain arithmetic.
module tb_ripple_count_ctrl;

   localparam int S   = 2;
   localparam int LIM = 300;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [1:0]      cmd_valid = '0;
   logic [1:0]      cmd_dir   = '0;
   logic [1:0]      clr_req   = '0;
   logic [1:0][3:0] cmd_steps = '0;
   logic [1:0][3:0] cnt_q;
   wire  [1:0]      cmd_ready, cnt_clk, cnt_rst, cnt_mode, cnt_jk, busy, done, sat, err;
   wire  [1:0][3:0] value;

   logic [1:0] stuck = '0;

   int n_tests = 0;
   int n_fail  = 0;

   int m_value[2];
   bit m_mode[2];
   bit m_err[2];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- DUTs ----------------
   ripple_count_ctrl #(.SIZE(4), .SETTLE_CYC(S), .WRAP_EN(1'b1)) u_wrap (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_dir(cmd_dir[0]), .cmd_steps(cmd_steps[0]), .clr_req(clr_req[0]),
      .cnt_q(cnt_q[0]), .cnt_clk(cnt_clk[0]), .cnt_rst(cnt_rst[0]),
      .cnt_mode(cnt_mode[0]), .cnt_jk(cnt_jk[0]), .value(value[0]),
      .busy(busy[0]), .done(done[0]), .sat(sat[0]), .err(err[0])
   );

   ripple_count_ctrl #(.SIZE(4), .SETTLE_CYC(S), .WRAP_EN(1'b0)) u_sat (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_dir(cmd_dir[1]), .cmd_steps(cmd_steps[1]), .clr_req(clr_req[1]),
      .cnt_q(cnt_q[1]), .cnt_clk(cnt_clk[1]), .cnt_rst(cnt_rst[1]),
      .cnt_mode(cnt_mode[1]), .cnt_jk(cnt_jk[1]), .value(value[1]),
      .busy(busy[1]), .done(done[1]), .sat(sat[1]), .err(err[1])
   );

   // ---------------- counter model + event monitor ----------------
   logic [3:0] ctr [2] = '{4'd0, 4'd0};
   logic [1:0] prev_clk  = '0;
   logic [1:0] prev_mode = '0;
   int pulse_cnt[2]  = '{0, 0};
   int done_cnt[2]   = '{0, 0};
   int jk_low_cnt[2] = '{0, 0};
   int glitch_cnt[2] = '{0, 0};

   assign cnt_q = {ctr[1] & (stuck[1] ? 4'b1101 : 4'b1111),
                   ctr[0] & (stuck[0] ? 4'b1101 : 4'b1111)};

   always @(posedge clk) begin
      #1;
      for (int g = 0; g < 2; g++) begin
         if (cnt_rst[g]) begin
            ctr[g] = 4'd0;
         end else begin
            // A mode-mux edge reaching a toggling stage corrupts the count.
            if ((cnt_mode[g] != prev_mode[g]) && cnt_jk[g]) begin
               glitch_cnt[g]++;
               ctr[g] = ctr[g] ^ 4'd1;
            end
            if (prev_clk[g] && !cnt_clk[g] && cnt_jk[g])
               ctr[g] = cnt_mode[g] ? ctr[g] - 4'd1 : ctr[g] + 4'd1;
         end
         if (!prev_clk[g] && cnt_clk[g]) pulse_cnt[g]++;
         if (done[g]) done_cnt[g]++;
         if (busy[g] && !cnt_jk[g]) jk_low_cnt[g]++;
         prev_clk[g]  = cnt_clk[g];
         prev_mode[g] = cnt_mode[g];
      end
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference: result of one command from the step rules.
   task automatic predict(input int v0, input bit mode0, input bit dir, input int steps,
                          input bit wrap, input bit fault,
                          output int v, output int pulses, output bit s, output bit e,
                          output bit sw, output int lat);
      int nv, q;
      v = v0; pulses = 0; s = 1'b0; e = 1'b0; sw = 1'b0;
      if (steps != 0) begin
         sw = (dir == mode0);            // mode 0 = up, dir 1 = up
         for (int i = 0; i < steps; i++) begin
            if (!wrap && ((dir && v == 15) || (!dir && v == 0))) begin
               s = 1'b1;
               break;
            end
            pulses++;
            nv = dir ? (v + 1) % 16 : (v + 15) % 16;
            q  = fault ? (nv & 'hD) : nv;
            if (q != nv) begin
               e = 1'b1;
               v = q;
               break;
            end
            v = nv;
         end
      end
      lat = 1 + (sw ? S : 0) + pulses * (3 + S);
   endtask

   task automatic check_reset_outputs(input int g, input string tag);
      check_eq({tag, "_cnt_rst"},  cnt_rst[g],  1);
      check_eq({tag, "_cnt_clk"},  cnt_clk[g],  0);
      check_eq({tag, "_cnt_mode"}, cnt_mode[g], 0);
      check_eq({tag, "_cnt_jk"},   cnt_jk[g],   0);
      check_eq({tag, "_value"},    value[g],    0);
      check_eq({tag, "_done"},     done[g],     0);
      check_eq({tag, "_sat"},      sat[g],      0);
      check_eq({tag, "_err"},      err[g],      0);
      check_eq({tag, "_ready"},    cmd_ready[g], 1);
      check_eq({tag, "_busy"},     busy[g],     0);
   endtask

   // ---------------- drivers ----------------
   task automatic do_cmd(input int g, input bit dir, input int steps);
      int ev, ep, el, lat, p0, d0, j0, gl0;
      bit es, ee, sw;
      predict(m_value[g], m_mode[g], dir, steps, (g == 0), stuck[g], ev, ep, es, ee, sw, el);
      p0 = pulse_cnt[g]; d0 = done_cnt[g]; j0 = jk_low_cnt[g]; gl0 = glitch_cnt[g];
      @(negedge clk);
      cmd_dir[g]   = dir;
      cmd_steps[g] = 4'(steps);
      cmd_valid[g] = 1'b1;
      check_eq("cmd_ready_before", cmd_ready[g], 1);
      @(posedge clk);
      #1;
      cmd_valid[g] = 1'b0;
      lat = 1;
      while (!done[g] && lat < LIM) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq("latency", lat, el);
      check_eq("sat", sat[g], es);
      @(negedge clk);
      @(negedge clk);
      check_eq("value",     value[g], ev);
      check_eq("err",       err[g], (m_err[g] | ee));
      check_eq("pulses",    pulse_cnt[g] - p0, ep);
      check_eq("done_once", done_cnt[g] - d0, 1);
      check_eq("jk_hold",   jk_low_cnt[g] - j0, sw ? S : 0);
      check_eq("glitch",    glitch_cnt[g] - gl0, 0);
      check_eq("idle",      cmd_ready[g] & ~busy[g], 1);
      m_value[g] = ev;
      if (sw) m_mode[g] = !dir;
      m_err[g] = m_err[g] | ee;
   endtask

   task automatic do_clr(input int g, input bit with_cmd);
      int n, d0;
      d0 = done_cnt[g];
      @(negedge clk);
      clr_req[g] = 1'b1;
      if (with_cmd) begin
         cmd_dir[g]   = 1'b1;
         cmd_steps[g] = 4'd3;
         cmd_valid[g] = 1'b1;
      end
      @(posedge clk);
      #1;
      clr_req[g]   = 1'b0;
      cmd_valid[g] = 1'b0;
      n = 1;
      while (!cmd_ready[g] && n < LIM) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("clr_latency", n, S + 2);
      @(negedge clk);
      @(negedge clk);
      check_eq("clr_value", value[g], 0);
      check_eq("clr_err",   err[g], 0);
      check_eq("clr_nodone", done_cnt[g] - d0, 0);
      check_eq("clr_ctr",   ctr[g], 0);
      m_value[g] = 0;
      m_err[g]   = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int g, r, st;
      for (int i = 0; i < 2; i++) begin
         m_value[i] = 0; m_mode[i] = 1'b0; m_err[i] = 1'b0;
      end
      // reset state
      repeat (3) @(negedge clk);
      check_reset_outputs(0, "rst0");
      check_reset_outputs(1, "rst1");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("cnt_rst_release0", cnt_rst[0], 0);
      check_eq("cnt_rst_release1", cnt_rst[1], 0);

      // count up, then reverse direction
      do_cmd(0, 1'b1, 5);
      do_cmd(0, 1'b0, 2);
      // zero steps, clear beats a simultaneous command
      do_cmd(0, 1'b1, 0);
      do_clr(0, 1'b1);
      // stuck bit 1: abort at the second check, clear removes err
      stuck[0] = 1'b1;
      do_cmd(0, 1'b1, 3);
      stuck[0] = 1'b0;
      do_clr(0, 1'b0);
      // wrap vs saturate at the top, saturate at zero after a mode switch
      do_cmd(0, 1'b1, 15);
      do_cmd(0, 1'b1, 2);
      do_cmd(1, 1'b1, 15);
      do_cmd(1, 1'b1, 2);
      do_cmd(1, 1'b0, 15);
      do_cmd(1, 1'b0, 1);
      do_cmd(1, 1'b1, 3);
      do_cmd(1, 1'b0, 5);

      // reset while a command is in SETTLE of its second step
      do_cmd(0, 1'b0, 1);
      @(negedge clk);
      cmd_dir[0] = 1'b0; cmd_steps[0] = 4'd3; cmd_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid[0] = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      check_eq("pre_rst_value", value[0], (m_value[0] + 15) % 16);
      check_eq("pre_rst_busy", busy[0], 1);
      r = done_cnt[0];
      rst = 1'b1;
      #1;
      check_reset_outputs(0, "midrst");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rst_hold_cnt_rst", cnt_rst[0], 1);
      @(posedge clk);
      #1;
      check_eq("rst_rel_cnt_rst", cnt_rst[0], 0);
      check_eq("rst_rel_ready", cmd_ready[0], 1);
      repeat (2) @(negedge clk);
      check_eq("rst_no_done", done_cnt[0] - r, 0);
      for (int i = 0; i < 2; i++) begin
         m_value[i] = 0; m_mode[i] = 1'b0; m_err[i] = 1'b0;
      end

      // randomized commands on both instances
      for (int k = 0; k < 40; k++) begin
         g = $urandom_range(0, 1);
         r = $urandom_range(0, 9);
         if (r == 0) begin
            do_clr(g, 1'($urandom_range(0, 1)));
         end else begin
            st = (r < 4) ? $urandom_range(0, 2) : $urandom_range(0, 15);
            do_cmd(g, 1'($urandom_range(0, 1)), st);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
